// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP gray-image fetch scheduler.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 14;
    localparam int CNT_W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        OFFER,
        DRAIN,
        DONE
    } sched_state_t;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [0:8] win_t;

    // Raster slot of window pixel at row offset dr, column offset dc.
    function automatic logic [3:0] win_slot(input logic [1:0] dr, input logic [1:0] dc);
        return 4'(dr) * 4'd3 + 4'(dc);
    endfunction

    function automatic win_t win_shift_left(input win_t w);
        win_t s;
        s = w;
        for (int r = 0; r < 3; r++) begin
            s[3*r]     = w[3*r + 1];
            s[3*r + 1] = w[3*r + 2];
            s[3*r + 2] = w[3*r + 2];
        end
        return s;
    endfunction

endpackage

// File: rtl/lbp_addr_gen.sv
// Centre row/col counters plus the 3x3 read offsets that form gray_addr.
module lbp_addr_gen #(
    parameter int IMG_W = lbp_pkg::IMG_W,
    parameter int IMG_H = lbp_pkg::IMG_H
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        init,
    input  logic                        rd_en,
    input  logic                        advance,
    input  logic                        shift_next,
    output logic [lbp_pkg::ADDR_W-1:0]  rd_addr,
    output logic [lbp_pkg::ADDR_W-1:0]  centre_addr,
    output logic [1:0]                  rd_row,
    output logic [1:0]                  rd_col,
    output logic                        burst_last,
    output logic                        row_end,
    output logic                        frame_end
);
    import lbp_pkg::*;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 2);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 2);

    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
    logic [1:0]        dr;
    logic [1:0]        dc;
    logic [ADDR_W-1:0] r_abs;
    logic [ADDR_W-1:0] c_abs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
            dr  <= '0;
            dc  <= '0;
        end else if (init) begin
            row <= CNT_W'(1);
            col <= CNT_W'(1);
            dr  <= '0;
            dc  <= '0;
        end else if (advance) begin
            // A SHIFT burst only fetches the new right-hand column.
            dr <= '0;
            dc <= shift_next ? 2'd2 : 2'd0;
            if (!row_end) begin
                col <= col + CNT_W'(1);
            end else begin
                col <= CNT_W'(1);
                if (!frame_end) begin
                    row <= row + CNT_W'(1);
                end
            end
        end else if (rd_en) begin
            if (dr == 2'd2) begin
                dr <= '0;
                dc <= dc + 2'd1;
            end else begin
                dr <= dr + 2'd1;
            end
        end
    end

    assign row_end    = (col == LAST_COL);
    assign frame_end  = row_end && (row == LAST_ROW);
    assign burst_last = (dr == 2'd2) && (dc == 2'd2);

    assign r_abs       = ADDR_W'(row) + ADDR_W'(dr) - ADDR_W'(1);
    assign c_abs       = ADDR_W'(col) + ADDR_W'(dc) - ADDR_W'(1);
    assign rd_addr     = r_abs * ADDR_W'(IMG_W) + c_abs;
    assign centre_addr = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    assign rd_row      = dr;
    assign rd_col      = dc;

endmodule

// File: rtl/lbp_fetch_sched.sv
// Gray-memory read scheduler building 3x3 windows for the LBP datapath.
// LBP_WINDOW_REUSE_EN: slide the window by one column instead of refilling all 9 pixels.
//
// state | meaning
// IDLE  | wait for gray_ready to begin the scan
// FILL  | 9 reads, full window around the centre
// SHIFT | 3 reads, new right-hand column only
// OFFER | window presented, waiting for win_ready
// DRAIN | scan done, waiting for lbp_idle
// DONE  | finish held until reset
module lbp_fetch_sched #(
    parameter int IMG_W = lbp_pkg::IMG_W,
    parameter int IMG_H = lbp_pkg::IMG_H
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          gray_ready,
    output logic                          gray_req,
    output logic [lbp_pkg::ADDR_W-1:0]    gray_addr,
    input  logic [lbp_pkg::PIX_W-1:0]     gray_data,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [9*lbp_pkg::PIX_W-1:0]   win_data,
    output logic [lbp_pkg::ADDR_W-1:0]    win_addr,
    input  logic                          lbp_idle,
    output logic                          finish
);
    import lbp_pkg::*;

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic              init;
    logic              rd_en;
    logic              advance;
    logic              shift_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] centre_addr;
    logic [1:0]        rd_row;
    logic [1:0]        rd_col;
    logic              burst_last;
    logic              row_end;
    logic              frame_end;
    logic [3:0]        slot;
    win_t              win_q;
    win_t              win_nxt;

    lbp_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .rd_en       (rd_en),
        .advance     (advance),
        .shift_next  (shift_next),
        .rd_addr     (rd_addr),
        .centre_addr (centre_addr),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .burst_last  (burst_last),
        .row_end     (row_end),
        .frame_end   (frame_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        init       = 1'b0;
        rd_en      = 1'b0;
        advance    = 1'b0;
        shift_next = 1'b0;
        case (state)
            IDLE: begin
                if (gray_ready) begin
                    init      = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL, SHIFT: begin
                rd_en = gray_ready;
                if (gray_ready && burst_last) begin
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (win_ready) begin
                    advance = 1'b1;
                    if (!row_end) begin
`ifdef LBP_WINDOW_REUSE_EN
                        shift_next = 1'b1;
                        state_nxt  = SHIFT;
`else
                        state_nxt  = FILL;
`endif
                    end else if (!frame_end) begin
                        state_nxt = FILL;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (lbp_idle) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign slot = win_slot(rd_row, rd_col);

    always_comb begin
        win_nxt = win_q;
        if (rd_en) begin
            win_nxt[slot] = gray_data;
        end
    end

    // Output registers load with the final pixel already merged, so the
    // offered window never shows a partially assembled state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q    <= '0;
            win_data <= '0;
            win_addr <= '0;
        end else begin
            if (rd_en) begin
                win_q <= win_nxt;
            end
`ifdef LBP_WINDOW_REUSE_EN
            else if (shift_next) begin
                win_q <= win_shift_left(win_q);
            end
`endif
            if (rd_en && burst_last) begin
                win_data <= win_nxt;
                win_addr <= centre_addr;
            end
        end
    end

    assign gray_req  = rd_en;
    assign gray_addr = rd_en ? rd_addr : '0;
    assign win_valid = (state == OFFER);
    assign finish    = (state == DONE);

endmodule

// File: tb/tb_lbp_fetch_sched.sv
// Directed bench for lbp_fetch_sched on a 128x4 image (2 interior rows, 252 windows).
`timescale 1ns/1ps
module tb_lbp_fetch_sched;

    localparam int W    = 128;
    localparam int H    = 4;
    localparam int NC   = W - 2;
    localparam int NWIN = (W - 2) * (H - 2);
`ifdef LBP_WINDOW_REUSE_EN
    localparam bit REUSE = 1'b1;
    localparam int NRD   = 768;
`else
    localparam bit REUSE = 1'b0;
    localparam int NRD   = 2268;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [13:0] win_addr;
    logic        lbp_idle;
    logic        finish;

    int          checks   = 0;
    int          failures = 0;
    bit          pat      = 1'b0;
    int          rd_w, rd_k, rd_cnt, xfer_cnt;
    logic [13:0] first_addr, last_addr;
    logic [71:0] first_data;

    always #5 clk = ~clk;

    assign gray_data = pat ? (gray_addr[7:0] ^ {1'b0, gray_addr[13:7]}) : gray_addr[7:0];

    lbp_fetch_sched #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .win_addr   (win_addr),
        .lbp_idle   (lbp_idle),
        .finish     (finish)
    );

    function automatic logic [7:0] pix(input logic [13:0] a);
        if (pat) return a[7:0] ^ {1'b0, a[13:7]};
        return a[7:0];
    endfunction

    function automatic logic [71:0] golden(input int w);
        int r, c;
        logic [71:0] v;
        r = 1 + w / NC;
        c = 1 + w % NC;
        v = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                v = {v[63:0], pix(14'((r - 1 + dr) * W + c - 1 + dc))};
        return v;
    endfunction

    function automatic logic [13:0] exp_rd_addr();
        int r, c;
        r = 1 + rd_w / NC;
        c = 1 + rd_w % NC;
        if (REUSE && c > 1) return 14'((r - 1 + rd_k) * W + c + 1);
        return 14'((r - 1 + rd_k % 3) * W + c - 1 + rd_k / 3);
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (gray_req) begin
            check("rd_gated", 72'(gray_ready), 72'(1));
            check("rd_addr", 72'(gray_addr), 72'(exp_rd_addr()));
            rd_cnt++;
            rd_k++;
            if (rd_k == ((REUSE && (rd_w % NC) != 0) ? 3 : 9)) begin
                rd_k = 0;
                rd_w++;
            end
        end
        if (win_valid) check("offer_no_rd", 72'(gray_req), 72'(0));
        if (win_valid && win_ready) begin
            if (xfer_cnt == 0) begin
                first_addr = win_addr;
                first_data = win_data;
            end
            last_addr = win_addr;
            check("win_addr", 72'(win_addr), 72'((1 + xfer_cnt / NC) * W + 1 + xfer_cnt % NC));
            check("win_data", win_data, golden(xfer_cnt));
            xfer_cnt++;
        end
    endtask

    task automatic drive(input logic rdy, input logic wr, input logic idle);
        gray_ready = rdy;
        win_ready  = wr;
        lbp_idle   = idle;
        #1;
        monitor();
    endtask

    task automatic reset_models();
        rd_w     = 0;
        rd_k     = 0;
        rd_cnt   = 0;
        xfer_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".gray_req"},  72'(gray_req),  72'(0));
        check({tag, ".gray_addr"}, 72'(gray_addr), 72'(0));
        check({tag, ".win_valid"}, 72'(win_valid), 72'(0));
        check({tag, ".win_data"},  win_data,       72'(0));
        check({tag, ".win_addr"},  72'(win_addr),  72'(0));
        check({tag, ".finish"},    72'(finish),    72'(0));
    endtask

    task automatic run_until(input int target, input int budget, input bit toggle,
                             input bit stall3, input logic idle);
        int   cyc   = 0;
        int   stall = 0;
        logic rdy, wr;
        while (xfer_cnt < target && cyc < budget) begin
            @(negedge clk);
            rdy = toggle ? (((cyc / 5) % 2) == 0) : 1'b1;
            wr  = !(stall3 && win_valid && xfer_cnt == 2 && stall < 20);
            drive(rdy, wr, idle);
            if (!wr) begin
                stall++;
                check("stall_addr", 72'(win_addr), 72'(131));
                check("stall_data", win_data, 72'h020304_828384_020304);
                check("stall_no_rd", 72'(gray_req), 72'(0));
            end
            cyc++;
        end
        check("reach_target", 72'(xfer_cnt), 72'(target));
        if (stall3) check("stall_len", 72'(stall), 72'(20));
    endtask

    initial begin
        reset      = 1'b0;
        gray_ready = 1'b0;
        win_ready  = 1'b0;
        lbp_idle   = 1'b0;
        reset_models();
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;

        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0);
            check("idle_no_req", 72'(gray_req), 72'(0));
            check("idle_no_valid", 72'(win_valid), 72'(0));
        end

        // Frame A: throttled memory, stalled third window, slow drain.
        run_until(NWIN, 8000, 1'b1, 1'b1, 1'b0);
        check("first_addr", 72'(first_addr), 72'(129));
        check("first_data", first_data, 72'h000102_808182_000102);
        check("last_addr", 72'(last_addr), 72'(382));
        check("rd_count_a", 72'(rd_cnt), 72'(NRD));
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0);
            check("drain_finish", 72'(finish), 72'(0));
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1);
        check("drain_last", 72'(finish), 72'(0));
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0);
        check("finish_rise", 72'(finish), 72'(1));
        repeat (5) begin
            @(negedge clk);
            drive(1'b1, 1'b1, 1'b0);
            check("done_finish", 72'(finish), 72'(1));
            check("done_valid", 72'(win_valid), 72'(0));
            check("done_req", 72'(gray_req), 72'(0));
        end
        check("rd_count_done", 72'(rd_cnt), 72'(NRD));

        // Frame B: reset from DONE, then abort mid-burst after window 299.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_done");
        pat = 1'b1;
        reset_models();
        @(negedge clk);
        reset = 1'b1;
        run_until(169, 4000, 1'b0, 1'b0, 1'b1);
        check("pre_abort_addr", 72'(last_addr), 72'(299));
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1);
        check("mid_burst_req", 72'(gray_req), 72'(1));
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(negedge clk);
        reset_models();
        @(negedge clk);
        reset = 1'b1;

        // Frame C: clean rescan must restart at the first centre.
        run_until(NWIN, 4000, 1'b0, 1'b0, 1'b1);
        check("restart_first", 72'(first_addr), 72'(129));
        check("restart_last", 72'(last_addr), 72'(382));
        check("rd_count_c", 72'(rd_cnt), 72'(NRD));
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1);
        check("finish_c", 72'(finish), 72'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
